// File: rtl/ssp_rx_ctrl.sv
// SSP receive controller: pulls bytes from the receive FIFO, packs them into words of
// 1..4 bytes and hands them to the host, flushing a stalled partial word after TIMEOUT idle cycles.
module ssp_rx_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [1:0]  cfg_bpw_i,
  input  logic        rx_empty_i,
  input  logic        rx_full_i,
  input  logic [7:0]  rx_d_i,
  output logic        do_read_o,
  output logic [31:0] word_o,
  output logic [2:0]  word_bytes_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        overrun_o,
  input  logic        ovr_clr_i,
  output logic        flush_o
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAP,
    PRES
  } state_e;

  localparam bit         TMO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  bpw_q, bpw_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] word_q, word_d;
  logic        do_read_q, do_read_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic        flush_q, flush_d;

  logic        idle_wait;
  logic        tmo_fire;
  logic [2:0]  cnt_next;
  logic        last_byte;

  // A partial word is stalled when nothing new can be fetched for it.
  assign idle_wait = (state_q == IDLE) && (cnt_q != 3'd0) && (rx_empty_i || !en_i);
  assign tmo_fire  = TMO_EN && idle_wait && (tmo_q == TMO_LAST);
  assign cnt_next  = cnt_q + 3'd1;
  assign last_byte = (cnt_next == ({1'b0, bpw_q} + 3'd1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      bpw_q     <= 2'd0;
      tmo_q     <= 8'd0;
      word_q    <= 32'd0;
      do_read_q <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bpw_q     <= bpw_d;
      tmo_q     <= tmo_d;
      word_q    <= word_d;
      do_read_q <= do_read_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      flush_q   <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bpw_d   = bpw_q;
    word_d  = word_q;
    // Saturate so a disabled timeout never wraps around.
    if (idle_wait) begin
      tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
    end else begin
      tmo_d = 8'd0;
    end

    case (state_q)
      IDLE: begin
        if (tmo_fire) begin
          state_d = PRES;
        end else if (en_i && !rx_empty_i) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = CAP;
        if (cnt_q == 3'd0) begin
          bpw_d = cfg_bpw_i;
        end
      end
      CAP: begin
        case (cnt_q[1:0])
          2'd0:    word_d[7:0]   = rx_d_i;
          2'd1:    word_d[15:8]  = rx_d_i;
          2'd2:    word_d[23:16] = rx_d_i;
          default: word_d[31:24] = rx_d_i;
        endcase
        cnt_d   = cnt_next;
        state_d = last_byte ? PRES : IDLE;
      end
      PRES: begin
        if (word_ready_i) begin
          state_d = IDLE;
          word_d  = 32'd0;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    do_read_d = (state_d == READ);
    valid_d   = (state_d == PRES);
    flush_d   = tmo_fire;
    ovr_d     = ovr_q;
    if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end
    if ((state_q == PRES) && rx_full_i) begin
      ovr_d = 1'b1;
    end
  end

  assign do_read_o    = do_read_q;
  assign word_o       = word_q;
  assign word_bytes_o = cnt_q;
  assign word_valid_o = valid_q;
  assign overrun_o    = ovr_q;
  assign flush_o      = flush_q;

endmodule

// File: tb/tb_ssp_rx_ctrl.sv
// Self-checking bench for ssp_rx_ctrl: directed scenarios followed by randomized byte streams
// scored against a word-packing model built from the byte stream itself.
module tb_ssp_rx_ctrl;

  localparam int TMO = 16;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  n;
    logic        f;
  } exp_t;

  logic        clk_i;
  logic        rst_i;
  logic        en_i;
  logic [1:0]  cfg_bpw_i;
  logic        rx_empty_i;
  logic        rx_full_i;
  logic [7:0]  rx_d_i;
  logic        do_read_o;
  logic [31:0] word_o;
  logic [2:0]  word_bytes_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        overrun_o;
  logic        ovr_clr_i;
  logic        flush_o;

  int          vectors;
  int          miscompares;
  int          cycle;
  int          lastRead;
  int          readCount;
  int          validCycle;
  bit          sbOn;
  logic        prevValid;
  logic        curFlush;
  logic [7:0]  fifoQ[$];
  int          readCycles[$];
  exp_t        expQ[$];

  ssp_rx_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .cfg_bpw_i    (cfg_bpw_i),
    .rx_empty_i   (rx_empty_i),
    .rx_full_i    (rx_full_i),
    .rx_d_i       (rx_d_i),
    .do_read_o    (do_read_o),
    .word_o       (word_o),
    .word_bytes_o (word_bytes_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .overrun_o    (overrun_o),
    .ovr_clr_i    (ovr_clr_i),
    .flush_o      (flush_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] cfg, input logic ready);
    en_i         = en;
    cfg_bpw_i    = cfg;
    word_ready_i = ready;
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoQ.push_back(b);
    rx_empty_i = 1'b0;
  endtask

  // One clock: score a handshake before the edge, then model the FIFO after it.
  task automatic tick();
    exp_t e;
    if (sbOn && word_valid_o === 1'b1 && word_ready_i === 1'b1) begin
      checkOutput("sb_pending", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("sb_word", word_o, e.w);
        checkOutput("sb_bytes", 32'(word_bytes_o), 32'(e.n));
        checkOutput("sb_flush", 32'(curFlush), 32'(e.f));
      end
    end
    @(posedge clk_i);
    #1;
    cycle++;
    if (word_valid_o === 1'b1 && prevValid !== 1'b1) curFlush = flush_o;
    prevValid = word_valid_o;
    if (do_read_o === 1'b1) begin
      checkOutput("read_gap", 32'((cycle - lastRead) > 1), 32'd1);
      checkOutput("read_nonempty", 32'(fifoQ.size() != 0), 32'd1);
      if (fifoQ.size() != 0) rx_d_i = fifoQ.pop_front();
      lastRead = cycle;
      readCount++;
      readCycles.push_back(cycle);
    end
    rx_empty_i = (fifoQ.size() == 0);
  endtask

  task automatic waitValid(input int maxCycles, input string tag);
    int n;
    n = 0;
    while (word_valid_o !== 1'b1 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(word_valid_o), 32'd1);
    validCycle = cycle;
  endtask

  task automatic waitRead(input int maxCycles, input string tag);
    int n;
    n = 0;
    while (do_read_o !== 1'b1 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(do_read_o), 32'd1);
  endtask

  initial begin
    int rc0;
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    lastRead    = -100;
    readCount   = 0;
    validCycle  = 0;
    sbOn        = 1'b0;
    prevValid   = 1'b0;
    curFlush    = 1'b0;
    rst_i       = 1'b1;
    rx_empty_i  = 1'b1;
    rx_full_i   = 1'b0;
    rx_d_i      = 8'h00;
    ovr_clr_i   = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0);

    // Reset values
    tick();
    tick();
    checkOutput("rst_do_read", 32'(do_read_o), 32'd0);
    checkOutput("rst_word", word_o, 32'd0);
    checkOutput("rst_bytes", 32'(word_bytes_o), 32'd0);
    checkOutput("rst_valid", 32'(word_valid_o), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_o), 32'd0);
    checkOutput("rst_flush", 32'(flush_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Full 4-byte word, reads three cycles apart
    readCycles.delete();
    applyStimulus(1'b1, 2'd3, 1'b1);
    pushByte(8'h11); pushByte(8'h22); pushByte(8'h33); pushByte(8'h44);
    waitValid(40, "t1_valid");
    checkOutput("t1_word", word_o, 32'h44332211);
    checkOutput("t1_bytes", 32'(word_bytes_o), 32'd4);
    checkOutput("t1_flush", 32'(flush_o), 32'd0);
    checkOutput("t1_nreads", 32'(readCycles.size()), 32'd4);
    for (int i = 1; i < readCycles.size(); i++) begin
      checkOutput("t1_spacing", 32'(readCycles[i] - readCycles[i-1]), 32'd3);
    end
    tick();
    checkOutput("t1_valid_drop", 32'(word_valid_o), 32'd0);
    checkOutput("t1_word_clr", word_o, 32'd0);

    // Partial word flushed by timeout
    applyStimulus(1'b1, 2'd3, 1'b0);
    pushByte(8'hAA); pushByte(8'hBB);
    waitValid(60, "t2_valid");
    checkOutput("t2_latency", 32'(validCycle - lastRead), 32'(2 + TMO));
    checkOutput("t2_word", word_o, 32'h0000BBAA);
    checkOutput("t2_bytes", 32'(word_bytes_o), 32'd2);
    checkOutput("t2_flush", 32'(flush_o), 32'd1);
    tick();
    checkOutput("t2_flush_pulse", 32'(flush_o), 32'd0);
    checkOutput("t2_hold_valid", 32'(word_valid_o), 32'd1);
    word_ready_i = 1'b1;
    tick();
    checkOutput("t2_valid_drop", 32'(word_valid_o), 32'd0);
    checkOutput("t2_bytes_clr", 32'(word_bytes_o), 32'd0);

    // Overrun set/clear priority, no reads while presenting
    applyStimulus(1'b1, 2'd0, 1'b0);
    pushByte(8'h5A);
    waitValid(20, "t3_valid");
    checkOutput("t3_ovr_init", 32'(overrun_o), 32'd0);
    pushByte(8'h6B);
    rc0 = readCount;
    rx_full_i = 1'b1;
    tick();
    rx_full_i = 1'b0;
    checkOutput("t3_ovr_set", 32'(overrun_o), 32'd1);
    tick();
    checkOutput("t3_ovr_sticky", 32'(overrun_o), 32'd1);
    ovr_clr_i = 1'b1;
    rx_full_i = 1'b1;
    tick();
    rx_full_i = 1'b0;
    checkOutput("t3_set_wins", 32'(overrun_o), 32'd1);
    tick();
    ovr_clr_i = 1'b0;
    checkOutput("t3_ovr_clr", 32'(overrun_o), 32'd0);
    checkOutput("t3_no_read_pres", 32'(readCount - rc0), 32'd0);
    checkOutput("t3_still_valid", 32'(word_valid_o), 32'd1);
    checkOutput("t3_word", word_o, 32'h0000005A);
    word_ready_i = 1'b1;
    tick();
    rx_full_i = 1'b1;
    tick();
    rx_full_i = 1'b0;
    checkOutput("t3_full_idle", 32'(overrun_o), 32'd0);
    waitValid(20, "t3_valid2");
    checkOutput("t3_word2", word_o, 32'h0000006B);
    tick();

    // Width change mid-word is ignored until the next word
    applyStimulus(1'b1, 2'd3, 1'b1);
    pushByte(8'h01); pushByte(8'h02); pushByte(8'h03); pushByte(8'h04); pushByte(8'h05);
    waitRead(10, "t4_first_read");
    tick();
    cfg_bpw_i = 2'd0;
    waitValid(40, "t4_valid");
    checkOutput("t4_word", word_o, 32'h04030201);
    checkOutput("t4_bytes", 32'(word_bytes_o), 32'd4);
    tick();
    waitValid(20, "t4_valid2");
    checkOutput("t4_word2", word_o, 32'h00000005);
    checkOutput("t4_bytes2", 32'(word_bytes_o), 32'd1);
    checkOutput("t4_flush2", 32'(curFlush), 32'd0);
    tick();

    // Reset during capture of the third byte
    applyStimulus(1'b1, 2'd3, 1'b1);
    pushByte(8'hA1); pushByte(8'hA2); pushByte(8'hA3);
    pushByte(8'hA4); pushByte(8'hA5); pushByte(8'hA6);
    rc0 = readCount;
    for (int i = 0; i < 20 && (readCount - rc0) < 3; i++) tick();
    checkOutput("t5_three_reads", 32'(readCount - rc0), 32'd3);
    tick();
    rst_i = 1'b1;
    cfg_bpw_i = 2'd2;
    tick();
    checkOutput("t5_do_read", 32'(do_read_o), 32'd0);
    checkOutput("t5_word", word_o, 32'd0);
    checkOutput("t5_bytes", 32'(word_bytes_o), 32'd0);
    checkOutput("t5_valid", 32'(word_valid_o), 32'd0);
    checkOutput("t5_overrun", 32'(overrun_o), 32'd0);
    checkOutput("t5_flush", 32'(flush_o), 32'd0);
    rst_i = 1'b0;
    waitValid(40, "t5_valid2");
    checkOutput("t5_word2", word_o, 32'h00A6A5A4);
    checkOutput("t5_bytes2", 32'(word_bytes_o), 32'd3);
    tick();

    // Disabled with data waiting, then enabled
    applyStimulus(1'b0, 2'd0, 1'b1);
    pushByte(8'h77);
    rc0 = readCount;
    repeat (50) tick();
    checkOutput("t6_no_reads", 32'(readCount - rc0), 32'd0);
    en_i = 1'b1;
    tick();
    checkOutput("t6_read_now", 32'(do_read_o), 32'd1);
    waitValid(10, "t6_valid");
    checkOutput("t6_word", word_o, 32'h00000077);
    tick();

    // Disable mid-word: capture completes, word flushes on timeout
    applyStimulus(1'b1, 2'd3, 1'b1);
    pushByte(8'hC1);
    waitRead(10, "t7_read");
    en_i = 1'b0;
    waitValid(60, "t7_valid");
    checkOutput("t7_latency", 32'(validCycle - lastRead), 32'(2 + TMO));
    checkOutput("t7_word", word_o, 32'h000000C1);
    checkOutput("t7_bytes", 32'(word_bytes_o), 32'd1);
    checkOutput("t7_flush", 32'(flush_o), 32'd1);
    tick();
    checkOutput("t7_valid_drop", 32'(word_valid_o), 32'd0);

    // Randomized byte streams with random host back-pressure
    sbOn = 1'b1;
    en_i = 1'b1;
    for (int s = 0; s < 24; s++) begin
      int          bpw;
      int          n;
      int          k;
      int          guard;
      logic [31:0] acc;
      logic [7:0]  b;
      bpw = int'($urandom_range(3, 0));
      n   = int'($urandom_range(9, 1));
      cfg_bpw_i = 2'(bpw);
      acc = 32'd0;
      k   = 0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(255, 0));
        pushByte(b);
        acc = acc | (32'(b) << (8 * k));
        k++;
        if (k == bpw + 1) begin
          expQ.push_back(exp_t'{w: acc, n: 3'(k), f: 1'b0});
          acc = 32'd0;
          k   = 0;
        end
      end
      if (k != 0) expQ.push_back(exp_t'{w: acc, n: 3'(k), f: 1'b1});
      guard = 0;
      while (!(expQ.size() == 0 && fifoQ.size() == 0 && word_valid_o === 1'b0) && guard < 400) begin
        word_ready_i = 1'($urandom_range(1, 0));
        tick();
        guard++;
      end
      checkOutput("rnd_drained", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
    sbOn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ssp_rx_ctrl.md
SSP_RX_CTRL -- requirements
Module: ssp_rx_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning idle clk_i cycles with a partial word and an empty FIFO before that word is flushed; 0 disables flushing; legal range 0..255.
REQ-002 clk_i  in  1  system clock; one clock; all logic SHALL be on the rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 en_i  in  1  enable; new FIFO reads start only while high.
REQ-005 cfg_bpw_i  in  2  bytes per word minus one (0 = 1 byte ... 3 = 4 bytes).
REQ-006 rx_empty_i  in  1  receive FIFO empty flag.
REQ-007 rx_full_i  in  1  receive FIFO full flag.
REQ-008 rx_d_i  in  8  receive FIFO read data; valid in the cycle after a do_read_o pulse.
REQ-009 do_read_o  out  1  receive FIFO read strike, one cycle per byte.
REQ-010 word_o  out  32  packed word; first received byte in [7:0]; unfilled bytes are zero.
REQ-011 word_bytes_o  out  3  number of valid bytes in word_o, 1..4.
REQ-012 word_valid_o  out  1  word_o and word_bytes_o are valid.
REQ-013 word_ready_i  in  1  host accepts the word.
REQ-014 overrun_o  out  1  sticky flag: the FIFO filled while a word was waiting for the host.
REQ-015 ovr_clr_i  in  1  clears overrun_o.
REQ-016 flush_o  out  1  one-cycle pulse when a partial word is presented because of timeout.

Function
REQ-017 The FSM SHALL have four states: IDLE, READ, CAP and PRES; all outputs SHALL be registered.
REQ-018 In IDLE, if en_i=1 and rx_empty_i=0, the next state SHALL be READ.
REQ-019 READ SHALL last exactly one cycle, with do_read_o=1 only in that cycle; the next state SHALL be CAP.
REQ-020 CAP SHALL write rx_d_i into byte lane cnt of the word register and increment cnt; if the new cnt equals bpw+1, the next state SHALL be PRES, otherwise IDLE.
REQ-021 Throughput SHALL be 3 cycles per byte, and back-to-back reads SHALL never issue do_read_o in consecutive cycles.
REQ-022 cfg_bpw_i SHALL be latched into bpw on the READ of the first byte of a word (cnt=0); changes mid-word SHALL be ignored.
REQ-023 In PRES, word_valid_o=1 and word_bytes_o=cnt.
  - When word_ready_i=1: in the next cycle word_valid_o=0, the word register is cleared, cnt=0 and the state returns to IDLE.
  - No FIFO read SHALL occur while in PRES.
REQ-024 The timeout counter SHALL increment each cycle when all of the following hold: state IDLE, cnt>0, and (rx_empty_i=1 or en_i=0).
  - It SHALL reset to 0 on any other cycle.
  - When it reaches TIMEOUT-1 and TIMEOUT!=0, the next state SHALL be PRES with word_bytes_o=cnt and flush_o pulsing for one cycle.
REQ-025 Deasserting en_i SHALL complete any in-flight READ/CAP and any pending PRES handshake; a partial word SHALL still flush by timeout.
REQ-026 overrun_o SHALL set in the cycle after rx_full_i=1 while in PRES, and SHALL clear the cycle after ovr_clr_i=1; on simultaneous set and clear, set wins.
REQ-027 rx_full_i SHALL have no effect outside PRES; rx_empty_i SHALL be sampled only in IDLE.

Reset
REQ-028 When rst_i=1, at the next edge:
  - state=IDLE, cnt=0, bpw=0 and the timeout counter=0;
  - do_read_o=0, word_o=0, word_bytes_o=0, word_valid_o=0, overrun_o=0, flush_o=0.
REQ-029 Reset mid-word or mid-PRES SHALL discard the partial or presented word with no further do_read_o.

Verification
REQ-030 cfg_bpw_i=3, FIFO holds 11,22,33,44, en_i=1, word_ready_i=1 -> four do_read_o pulses 3 cycles apart; word_o=0x44332211, word_bytes_o=4, word_valid_o for 1 cycle.
REQ-031 cfg_bpw_i=3, only bytes AA,BB delivered, TIMEOUT=16 -> 16 idle cycles after the second CAP, then word_o=0x0000BBAA, word_bytes_o=2, flush_o pulse.
REQ-032 Word presented with word_ready_i=0, rx_full_i raised for 1 cycle -> overrun_o=1 and held; ovr_clr_i together with another rx_full_i -> still 1; ovr_clr_i alone -> 0.
REQ-033 cfg_bpw_i changed from 3 to 0 after the first byte -> word still completes at 4 bytes; the next word is 1 byte.
REQ-034 rst_i asserted in CAP of the 3rd byte -> next cycle all outputs 0, the following word starts at lane 0.
REQ-035 en_i=0 with FIFO non-empty and cnt=0 -> no do_read_o for 50 cycles; en_i=1 -> read in the next READ.
